// File: rtl/mem_stage_sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl_if
//   Pin bundle for an external 16-bit asynchronous SRAM.
//   master : memory controller (drives address, write data, strobes)
//   slave  : SRAM device / SRAM model (drives read data)
//   Signals:
//     sram_addr   half-word address
//     sram_wdata  write data
//     sram_rdata  read data, valid while sram_oe_n is low
//     sram_we_n   write strobe, active low
//     sram_oe_n   output enable, active low
// ---------------------------------------------------------------------------
interface mem_stage_sram_ctrl_if #(
  parameter int SRAM_AW = 18
);
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we_n,
    output sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we_n,
    input  sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_sram_ctrl
//   Pipeline memory stage. Takes the EX/MEM register outputs, performs a
//   32-bit load or store as two 16-bit accesses on an asynchronous SRAM
//   (low half-word first), and drives the MEM/WB pipeline register. While an
//   access is in flight, freeze holds the rest of the pipeline.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     wb_en_in .. dest_in      EX/MEM register outputs
//     wb_en_out .. dest_out    MEM/WB register
//     wb_en_hazard, dest_hazard, mem_wb_value
//                              live taps of the EX/MEM values for the hazard
//                              unit and EX forwarding
//     freeze                   1 = hold PC and IF/ID/EX/MEM registers
//     sram                     SRAM pin bundle (master side)
//     dbg_state_o              FSM state: 0 idle, 1 low half, 2 high half,
//                              3 done
//
//   Request handshake: a request is "valid" whenever mem_r_en_in or
//   mem_w_en_in is high. freeze acts as the inverted "ready": while it is 1
//   the upstream stage must hold every EX/MEM input stable; the request is
//   consumed on the rising edge where freeze is 0 (the DONE cycle), which is
//   also the edge that loads the MEM/WB register.
// ---------------------------------------------------------------------------
module mem_stage_sram_ctrl #(
  parameter int          DATA_W      = 32,
  parameter int          DEST_W      = 4,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 5,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 wb_en_in,
  input  logic                 mem_r_en_in,
  input  logic                 mem_w_en_in,
  input  logic [DATA_W-1:0]    alu_res_in,
  input  logic [DATA_W-1:0]    val_Rm_in,
  input  logic [DEST_W-1:0]    dest_in,

  output logic                 wb_en_out,
  output logic                 mem_r_en_out,
  output logic [DATA_W-1:0]    alu_res_out,
  output logic [DATA_W-1:0]    mem_data_out,
  output logic [DEST_W-1:0]    dest_out,

  output logic                 wb_en_hazard,
  output logic [DEST_W-1:0]    dest_hazard,
  output logic [DATA_W-1:0]    mem_wb_value,

  output logic                 freeze,

  mem_stage_sram_ctrl_if.master sram,

  output logic [1:0]           dbg_state_o
);

  localparam int CNT_W  = $clog2(WAIT_CYCLES);
  localparam int WORD_W = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       rd_lo_q, rd_lo_d;
  logic [15:0]       rd_hi_q, rd_hi_d;

  logic              wb_en_q;
  logic              mem_r_en_q;
  logic [DATA_W-1:0] alu_res_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DEST_W-1:0] dest_q;

  logic              is_mem;
  logic              is_load;
  logic              is_store;
  logic              last_cycle;
  logic              in_access;
  logic [DATA_W-1:0] byte_offset;
  logic [WORD_W-1:0] word_addr;

  logic [SRAM_AW-1:0] addr_d;
  logic [15:0]        wdata_d;
  logic               we_n_d;
  logic               oe_n_d;

  // Load wins when both enables are set, so a store is only a pure store.
  assign is_mem     = mem_r_en_in | mem_w_en_in;
  assign is_load    = mem_r_en_in;
  assign is_store   = mem_w_en_in & ~mem_r_en_in;
  assign last_cycle = (cnt_q == CNT_LAST);
  assign in_access  = (state_q == S_LO) || (state_q == S_HI);

  // Addresses below BASE_ADDR wrap through the subtraction; the low two
  // byte bits are dropped and the word index is truncated to the SRAM size.
  assign byte_offset = alu_res_in - DATA_W'(BASE_ADDR);
  assign word_addr   = WORD_W'(byte_offset >> 2);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_lo_q <= '0;
      rd_hi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_lo_q <= rd_lo_d;
      rd_hi_q <= rd_hi_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state, wait counter and read-data capture
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_mem) begin
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (last_cycle) begin
          state_d = S_HI;
          cnt_d   = '0;
          // Data has had the whole hold window to settle; take it at the end.
          if (is_load) begin
            rd_lo_d = sram.sram_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (last_cycle) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (is_load) begin
            rd_hi_d = sram.sram_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Always go back to idle so a still-held request is not re-issued
        // before the MEM/WB register has taken it.
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // SRAM bus drive: quiet (strobes high, address/data 0) outside LO/HI
  // -------------------------------------------------------------------------
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    if (in_access) begin
      addr_d = {word_addr, (state_q == S_HI)};
      if (is_load) begin
        oe_n_d = 1'b0;
      end else if (is_store) begin
        we_n_d  = 1'b0;
        wdata_d = (state_q == S_HI) ? 16'(val_Rm_in >> 16) : val_Rm_in[15:0];
      end
    end
  end

  assign sram.sram_addr  = addr_d;
  assign sram.sram_wdata = wdata_d;
  assign sram.sram_we_n  = we_n_d;
  assign sram.sram_oe_n  = oe_n_d;

  // Freeze rises in the same cycle a memory op shows up in idle, so the
  // upstream stage never advances past an unserviced access.
  assign freeze = ~rst & (((state_q == S_IDLE) & is_mem) | in_access);

  // -------------------------------------------------------------------------
  // MEM/WB pipeline register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (!freeze) begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      alu_res_q  <= alu_res_in;
      dest_q     <= dest_in;
      // Only reachable with a load in the DONE cycle; other ops keep the
      // previous load data.
      if (mem_r_en_in) begin
        mem_data_q <= DATA_W'({rd_hi_q, rd_lo_q});
      end
    end
  end

  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;

  assign wb_en_hazard = wb_en_in;
  assign dest_hazard  = dest_in;
  assign mem_wb_value = alu_res_in;

  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_sram_ctrl
//   Drives EX/MEM operations into mem_stage_sram_ctrl, emulates the SRAM
//   device, and compares the stage against a word-level memory model.
// ---------------------------------------------------------------------------
module tb_mem_stage_sram_ctrl;

  localparam int WAITC = 5;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_Rm_in;
  logic [3:0]  dest_in;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [31:0] alu_res_out;
  logic [31:0] mem_data_out;
  logic [3:0]  dest_out;
  logic        wb_en_hazard;
  logic [3:0]  dest_hazard;
  logic [31:0] mem_wb_value;
  logic        freeze;
  logic [1:0]  dbg_state;

  mem_stage_sram_ctrl_if #(.SRAM_AW(18)) sram_bus ();

  mem_stage_sram_ctrl #(
    .DATA_W(32), .DEST_W(4), .SRAM_AW(18), .WAIT_CYCLES(WAITC), .BASE_ADDR(1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_res_in   (alu_res_in),
    .val_Rm_in    (val_Rm_in),
    .dest_in      (dest_in),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out),
    .wb_en_hazard (wb_en_hazard),
    .dest_hazard  (dest_hazard),
    .mem_wb_value (mem_wb_value),
    .freeze       (freeze),
    .sram         (sram_bus),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- SRAM device emulation ----------------
  logic [15:0] sram_mem [0:262143];

  always @(posedge clk) begin
    if (!sram_bus.sram_we_n) sram_mem[sram_bus.sram_addr] <= sram_bus.sram_wdata;
  end
  assign sram_bus.sram_rdata = sram_bus.sram_oe_n ? 16'h0000 : sram_mem[sram_bus.sram_addr];

  // ---------------- scoreboard / reference model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [int];   // word index -> 32-bit value
  logic [31:0] exp_mem_data = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] byte_addr);
    logic [31:0] off;
    off = byte_addr - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  // One EX/MEM operation. Called one time step after a rising edge; returns
  // one time step after the edge that loaded MEM/WB. With chain=0 the inputs
  // go idle and the following cycle is checked for no re-issue.
  task automatic run_op(input logic wb, input logic r, input logic w,
                        input logic [31:0] alu, input logic [31:0] val,
                        input logic [3:0] dest, input bit chain);
    int fz, we, oe, cyc, wi;
    logic [31:0] exp_word;
    wb_en_in    = wb;
    mem_r_en_in = r;
    mem_w_en_in = w;
    alu_res_in  = alu;
    val_Rm_in   = val;
    dest_in     = dest;
    fz = 0; we = 0; oe = 0; cyc = 0;
    @(negedge clk);
    chk("haz_wb_en", 32'(wb_en_hazard), 32'(wb));
    chk("haz_dest", 32'(dest_hazard), 32'(dest));
    chk("fwd_value", mem_wb_value, alu);
    while (freeze && cyc < 64) begin
      fz++;
      if (!sram_bus.sram_we_n) we++;
      if (!sram_bus.sram_oe_n) oe++;
      cyc++;
      @(negedge clk);
    end
    chk("freeze_len", 32'(fz), (r || w) ? 32'(2 * WAITC + 1) : 32'd0);
    chk("we_n_low_cycles", 32'(we), (w && !r) ? 32'(2 * WAITC) : 32'd0);
    chk("oe_n_low_cycles", 32'(oe), r ? 32'(2 * WAITC) : 32'd0);
    @(posedge clk);
    #1;
    wi = word_of(alu);
    if (w && !r) ref_mem[wi] = val;
    if (r) exp_mem_data = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    chk("wb_en_out", 32'(wb_en_out), 32'(wb));
    chk("mem_r_en_out", 32'(mem_r_en_out), 32'(r));
    chk("alu_res_out", alu_res_out, alu);
    chk("dest_out", 32'(dest_out), 32'(dest));
    chk("mem_data_out", mem_data_out, exp_mem_data);
    if ((r || w) && ref_mem.exists(wi)) begin
      exp_word = ref_mem[wi];
      chk("sram_lo_half", 32'(sram_mem[2 * wi]), 32'(exp_word[15:0]));
      chk("sram_hi_half", 32'(sram_mem[2 * wi + 1]), 32'(exp_word[31:16]));
    end
    wb_en_in    = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    if (!chain) begin
      @(negedge clk);
      chk("no_reissue_freeze", 32'(freeze), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, kind, wi;
    logic [31:0] a;
    rst         = 1'b1;
    wb_en_in    = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    alu_res_in  = 32'h0;
    val_Rm_in   = 32'h0;
    dest_in     = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    chk("rst_oe_n", 32'(sram_bus.sram_oe_n), 32'd1);
    chk("rst_addr", 32'(sram_bus.sram_addr), 32'd0);
    chk("rst_wdata", 32'(sram_bus.sram_wdata), 32'd0);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);
    chk("rst_wb_en_out", 32'(wb_en_out), 32'd0);
    chk("rst_mem_data_out", mem_data_out, 32'd0);
    rst = 1'b0;

    // non-memory op
    run_op(1'b1, 1'b0, 1'b0, 32'h55, 32'h1234, 4'd3, 1'b0);
    // store then load at 1028 (half-words 2 and 3)
    run_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0, 1'b0);
    chk("sram_hw2", 32'(sram_mem[2]), 32'hBEEF);
    chk("sram_hw3", 32'(sram_mem[3]), 32'hDEAD);
    run_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd7, 1'b0);
    chk("load_1028", mem_data_out, 32'hDEADBEEF);

    // reset in the middle of a store
    wb_en_in    = 1'b1;
    mem_w_en_in = 1'b1;
    alu_res_in  = 32'd1424;
    val_Rm_in   = $urandom;
    dest_in     = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    rst         = 1'b1;
    wb_en_in    = 1'b0;
    mem_w_en_in = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    chk("abort_freeze", 32'(freeze), 32'd0);
    chk("abort_wb_en_out", 32'(wb_en_out), 32'd0);
    chk("abort_mem_r_en_out", 32'(mem_r_en_out), 32'd0);
    chk("abort_alu_res_out", alu_res_out, 32'd0);
    chk("abort_mem_data_out", mem_data_out, 32'd0);
    chk("abort_dest_out", 32'(dest_out), 32'd0);
    exp_mem_data = 32'h0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // both enables: load wins, nothing written
    run_op(1'b0, 1'b0, 1'b1, 32'd1024, $urandom, 4'd1, 1'b0);
    run_op(1'b1, 1'b1, 1'b1, 32'd1024, ~ref_mem[0], 4'd2, 1'b0);

    // back-to-back loads with no gap
    run_op(1'b0, 1'b0, 1'b1, 32'd1032, $urandom, 4'd0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd8, 1'b1);
    run_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd9, 1'b0);

    // below BASE_ADDR wraps to the top of the SRAM; low bits ignored
    run_op(1'b0, 1'b0, 1'b1, 32'd1020, $urandom, 4'd0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 32'd1023, 32'h0, 4'd4, 1'b0);
    chk("wrap_hw_top", 32'(sram_mem[262143]), 32'(ref_mem[32'h1FFFF] >> 16));

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      k    = $urandom_range(0, 15);
      a    = 32'd1024 + 32'(4 * k) + 32'($urandom_range(0, 3));
      wi   = word_of(a);
      if (kind == 1 && !ref_mem.exists(wi)) kind = 0;
      case (kind)
        0:       run_op(1'($urandom_range(0, 1)), 1'b0, 1'b1, a, $urandom,
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        1:       run_op(1'($urandom_range(0, 1)), 1'b1, 1'b0, a, $urandom,
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        default: run_op(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom, $urandom,
                        4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
